// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Merges ALU and LSB results onto a single common data bus (CDB). Each
// source has its own small FIFO. A result that finds its FIFO empty and wins
// arbitration goes straight to the bus (bypass). Otherwise it is queued and
// leaves in arrival order. When both sources have a candidate, grants
// alternate between them.
//
// Ports
//   clk_in, rst_in         clock, synchronous active-high reset
//   rdy_in                 global enable; when low, everything holds
//   clear                  flush (mispredict): empties both FIFOs
//   alu_ready/rob_id/result  ALU result pulse (no backpressure)
//   lsb_ready/rob_id/result  LSB result pulse (no backpressure)
//   alu_stall, lsb_stall   combinational near-full indications
//   cdb_req/rob_id/val     registered broadcast
//   overflow               registered sticky drop flag

`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_BITS   = `ROB_INDEX_BIT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                alu_ready,
  input  logic [ROB_BITS-1:0] alu_rob_id,
  input  logic [31:0]         alu_result,
  input  logic                lsb_ready,
  input  logic [ROB_BITS-1:0] lsb_rob_id,
  input  logic [31:0]         lsb_result,
  output logic                alu_stall,
  output logic                lsb_stall,
  output logic                cdb_req,
  output logic [ROB_BITS-1:0] cdb_rob_id,
  output logic [31:0]         cdb_val,
  output logic                overflow
);

  localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS   = PTR_BITS + 1;
  localparam int ENTRY_BITS = ROB_BITS + 32;
  localparam logic [CNT_BITS-1:0] FULL_CNT  = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] STALL_CNT = CNT_BITS'(FIFO_DEPTH - 2);
  // Source index 0 is the ALU, index 1 is the LSB.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic [ENTRY_BITS-1:0] mem_r [2][FIFO_DEPTH];
  logic [PTR_BITS-1:0]   rd_r  [2];
  logic [PTR_BITS-1:0]   wr_r  [2];
  logic [CNT_BITS-1:0]   cnt_r [2];
  logic                  last_grant_r;
  logic                  cdb_req_r;
  logic [ROB_BITS-1:0]   cdb_rob_id_r;
  logic [31:0]           cdb_val_r;
  logic                  overflow_r;

  logic [ENTRY_BITS-1:0] in_entry_s   [2];
  logic [ENTRY_BITS-1:0] cand_entry_s [2];
  logic [1:0]            in_valid_s;
  logic [1:0]            has_head_s;
  logic [1:0]            cand_s;
  logic [1:0]            pop_s;
  logic [1:0]            bypass_s;
  logic [1:0]            push_s;
  logic                  grant_any_s;
  logic                  winner_s;
  logic                  drop_s;
  logic [ENTRY_BITS-1:0] winner_entry_s;

  // Candidate selection, arbitration and push/pop decisions for this cycle.
  always_comb begin
    in_valid_s    = {lsb_ready, alu_ready};
    in_entry_s[0] = {alu_rob_id, alu_result};
    in_entry_s[1] = {lsb_rob_id, lsb_result};
    has_head_s    = 2'b00;
    cand_s        = 2'b00;
    pop_s         = 2'b00;
    bypass_s      = 2'b00;
    push_s        = 2'b00;
    drop_s        = 1'b0;
    for (int s = 0; s < 2; s++) begin
      has_head_s[s] = (cnt_r[s] != '0);
      cand_s[s]     = has_head_s[s] | in_valid_s[s];
      if (has_head_s[s]) begin
        cand_entry_s[s] = mem_r[s][rd_r[s]];
      end else begin
        cand_entry_s[s] = in_entry_s[s];
      end
    end
    grant_any_s = |cand_s;
    // On a tie, the source that did not win last time gets the bus.
    if (cand_s == 2'b11) begin
      winner_s = ~last_grant_r;
    end else if (cand_s[1]) begin
      winner_s = SRC_LSB;
    end else begin
      winner_s = SRC_ALU;
    end
    winner_entry_s = cand_entry_s[winner_s];
    for (int s = 0; s < 2; s++) begin
      pop_s[s]    = grant_any_s && (winner_s == s[0]) && has_head_s[s];
      bypass_s[s] = grant_any_s && (winner_s == s[0]) && !has_head_s[s];
      // A full FIFO still accepts a push when its head leaves this cycle.
      if (in_valid_s[s] && !bypass_s[s]) begin
        if ((cnt_r[s] != FULL_CNT) || pop_s[s]) begin
          push_s[s] = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_s[s] = 1'b0;
      end
    end
  end

  // FIFO storage writes; data needs no reset because counts gate every read.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !clear) begin
      for (int s = 0; s < 2; s++) begin
        if (push_s[s]) begin
          mem_r[s][wr_r[s]] <= in_entry_s[s];
        end
      end
    end
  end

  // Pointers, counts, grant history, broadcast registers and overflow flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        rd_r[s]  <= '0;
        wr_r[s]  <= '0;
        cnt_r[s] <= '0;
      end
      last_grant_r <= SRC_LSB;
      cdb_req_r    <= 1'b0;
      cdb_rob_id_r <= '0;
      cdb_val_r    <= 32'h0000_0000;
      overflow_r   <= 1'b0;
    end else if (!rdy_in) begin
      last_grant_r <= last_grant_r;
    end else if (clear) begin
      for (int s = 0; s < 2; s++) begin
        rd_r[s]  <= '0;
        wr_r[s]  <= '0;
        cnt_r[s] <= '0;
      end
      cdb_req_r <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push_s[s]) begin
          wr_r[s] <= wr_r[s] + PTR_BITS'(1);
        end
        if (pop_s[s]) begin
          rd_r[s] <= rd_r[s] + PTR_BITS'(1);
        end
        cnt_r[s] <= cnt_r[s] + CNT_BITS'(push_s[s]) - CNT_BITS'(pop_s[s]);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      cdb_req_r <= grant_any_s;
      if (grant_any_s) begin
        cdb_rob_id_r <= winner_entry_s[ENTRY_BITS-1:32];
        cdb_val_r    <= winner_entry_s[31:0];
        last_grant_r <= winner_s;
      end
    end
  end

  assign alu_stall  = (cnt_r[0] >= STALL_CNT);
  assign lsb_stall  = (cnt_r[1] >= STALL_CNT);
  assign cdb_req    = cdb_req_r;
  assign cdb_rob_id = cdb_rob_id_r;
  assign cdb_val    = cdb_val_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter. A queue-based reference model of the
// two result buffers and the alternating grant rule predicts every output
// after each clock edge. Directed scenarios cover the documented cases, and
// a randomized phase exercises mixed traffic, flushes and pauses.

module tb_cdb_arbiter;

  localparam int DEPTH = 4;
  localparam int RB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          clr = 1'b0;
  logic          a_rdy = 1'b0;
  logic [RB-1:0] a_id = '0;
  logic [31:0]   a_val = 32'h0;
  logic          l_rdy = 1'b0;
  logic [RB-1:0] l_id = '0;
  logic [31:0]   l_val = 32'h0;
  logic          alu_stall, lsb_stall, cdb_req, overflow;
  logic [RB-1:0] cdb_rob_id;
  logic [31:0]   cdb_val;

  cdb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_BITS(RB)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
    .alu_ready(a_rdy), .alu_rob_id(a_id), .alu_result(a_val),
    .lsb_ready(l_rdy), .lsb_rob_id(l_id), .lsb_result(l_val),
    .alu_stall(alu_stall), .lsb_stall(lsb_stall),
    .cdb_req(cdb_req), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [RB+31:0] q_alu[$];
  logic [RB+31:0] q_lsb[$];
  logic           m_last = 1'b1;
  logic           m_req = 1'b0;
  logic [RB-1:0]  m_id = '0;
  logic [31:0]    m_val = 32'h0;
  logic           m_ov = 1'b0;

  wire [RB+35:0] act_vec = {cdb_req, cdb_rob_id, cdb_val, overflow, alu_stall, lsb_stall};

  function automatic logic [RB+35:0] exp_vec();
    return {m_req, m_id, m_val, m_ov,
            1'(q_alu.size() >= DEPTH - 2), 1'(q_lsb.size() >= DEPTH - 2)};
  endfunction

  // One cycle of the documented behaviour, applied to the current inputs.
  function automatic void model_step();
    logic a_has, l_has, a_c, l_c, any, win;
    logic [RB+31:0] a_e, l_e, w_e;
    if (rst) begin
      q_alu.delete(); q_lsb.delete();
      m_last = 1'b1; m_ov = 1'b0; m_req = 1'b0; m_id = '0; m_val = 32'h0;
      return;
    end
    if (!rdy) return;
    if (clr) begin
      q_alu.delete(); q_lsb.delete(); m_req = 1'b0;
      return;
    end
    a_has = (q_alu.size() > 0);
    l_has = (q_lsb.size() > 0);
    a_c = a_has || a_rdy;
    l_c = l_has || l_rdy;
    a_e = a_has ? q_alu[0] : {a_id, a_val};
    l_e = l_has ? q_lsb[0] : {l_id, l_val};
    any = a_c || l_c;
    win = (a_c && l_c) ? ~m_last : l_c;   // 1 = LSB
    if (any) begin
      w_e = win ? l_e : a_e;
      m_req = 1'b1; m_id = w_e[RB+31:32]; m_val = w_e[31:0]; m_last = win;
      if (!win && a_has) void'(q_alu.pop_front());
      if (win && l_has) void'(q_lsb.pop_front());
    end else begin
      m_req = 1'b0;
    end
    if (a_rdy && !(any && !win && !a_has)) begin
      if (q_alu.size() < DEPTH) q_alu.push_back({a_id, a_val}); else m_ov = 1'b1;
    end
    if (l_rdy && !(any && win && !l_has)) begin
      if (q_lsb.size() < DEPTH) q_lsb.push_back({l_id, l_val}); else m_ov = 1'b1;
    end
  endfunction

  // Advance one clock: update the model, let the edge pass, sample at +1,
  // then drop the single-cycle pulses.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    a_rdy = 1'b0; l_rdy = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b0; clr = 1'b1;
    a_rdy = 1'b1; a_id = 4'd5; a_val = 32'hDEAD_BEEF;
    tick();
    tick();
    checks++;
    if (act_vec !== {(RB+36){1'b0}}) begin
      errors++;
      $display("FAIL reset_state: got %h want all zero", act_vec);
    end
    rst = 1'b0; rdy = 1'b1;
    tick();
    checks++;
    if (cdb_req !== 1'b0 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    a_rdy = 1'b1; a_id = 4'd3; a_val = 32'h11;
    tick();
    checks++;
    if (cdb_req !== 1'b1 || cdb_rob_id !== 4'd3 || cdb_val !== 32'h11) begin
      errors++;
      $display("FAIL single_bcast: got req=%b id=%0d val=%h want req=1 id=3 val=11", cdb_req, cdb_rob_id, cdb_val);
    end
    tick();
    checks++;
    if (cdb_req !== 1'b0 || cdb_rob_id !== 4'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got req=%b id=%0d ov=%b want req=0 id=3 ov=0", cdb_req, cdb_rob_id, overflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [RB-1:0] got[$];
    logic [RB-1:0] want[$];
    want = '{4'd1, 4'd2};
    do_reset();
    a_rdy = 1'b1; a_id = 4'd1; a_val = 32'hA1;
    l_rdy = 1'b1; l_id = 4'd2; l_val = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cdb_req === 1'b1) got.push_back(cdb_rob_id);
    end
    checks++;
    if (got != want || cdb_req !== 1'b0 || alu_stall !== 1'b0 || lsb_stall !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: got ids=%p req=%b want ids=%p req=0", got, cdb_req, want);
    end
  endtask

  task automatic test_alternate();
    logic [RB-1:0] got[$];
    logic [RB-1:0] want[$];
    bit saw_stall = 0;
    want = '{4'd4, 4'd8, 4'd5, 4'd9, 4'd6, 4'd10, 4'd7, 4'd11};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        a_rdy = 1'b1; a_id = RB'(4 + i); a_val = 32'h100 + i;
        l_rdy = 1'b1; l_id = RB'(8 + i); l_val = 32'h200 + i;
      end
      tick();
      if (cdb_req === 1'b1) got.push_back(cdb_rob_id);
      if (alu_stall === 1'b1) saw_stall = 1;
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL alternate cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (got != want || !saw_stall || overflow !== 1'b0) begin
      errors++;
      $display("FAIL alternate_order: got %p stall_seen=%0d ov=%b want %p stall_seen=1 ov=0", got, saw_stall, overflow, want);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      a_rdy = 1'b1; a_id = RB'(i); a_val = 32'h300 + i;
      l_rdy = 1'b1; l_id = RB'(i + 3); l_val = 32'h400 + i;
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_fill cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_drain cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    checks++;
    if (overflow !== 1'b1 || cdb_req !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky: got ov=%b req=%b want ov=1 req=0", overflow, cdb_req);
    end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_reset: got ov=%b want 0", overflow);
    end
  endtask

  task automatic test_clear();
    bit leaked = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_rdy = 1'b1; a_id = RB'(12 + i); a_val = 32'h500 + i;
      l_rdy = 1'b1; l_id = RB'(1 + i); l_val = 32'h600 + i;
      tick();
    end
    clr = 1'b1;
    a_rdy = 1'b1; a_id = 4'd15; a_val = 32'h777;
    tick();
    checks++;
    if (cdb_req !== 1'b0 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clear_next: got %h want %h", act_vec, exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cdb_req !== 1'b0 || alu_stall !== 1'b0 || lsb_stall !== 1'b0) leaked = 1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("FAIL clear_flush: got buffered broadcast or stall after flush, want none");
    end
  endtask

  task automatic test_pause();
    logic [RB+35:0] snap;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_rdy = 1'b1; a_id = RB'(2 + i); a_val = 32'h800 + i;
      l_rdy = 1'b1; l_id = RB'(9 + i); l_val = 32'h900 + i;
      tick();
    end
    snap = act_vec;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_rdy = 1'b1; a_id = 4'd14; a_val = 32'hBAD;
      l_rdy = 1'b1; l_id = 4'd13; l_val = 32'hBAD;
      tick();
      checks++;
      if (act_vec !== snap || act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pause_hold cyc%0d: got %h want %h", i, act_vec, snap);
      end
    end
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL pause_resume cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_rdy = 1'b1; a_id = RB'(i); a_val = 32'hC00 + i;
      l_rdy = 1'b1; l_id = RB'(i + 8); l_val = 32'hD00 + i;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cdb_req !== 1'b0 || alu_stall !== 1'b0 || lsb_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b stall=%b%b want req=0 stall=00", cdb_req, alu_stall, lsb_stall);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_rdy = 1'($urandom_range(0, 1));
      a_id  = RB'($urandom);
      a_val = $urandom;
      l_rdy = 1'($urandom_range(0, 1));
      l_id  = RB'($urandom);
      l_val = $urandom;
      clr   = ($urandom_range(0, 29) == 0);
      rdy   = ($urandom_range(0, 7) != 0);
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    rdy = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_simultaneous();
    test_alternate();
    test_overflow();
    test_clear();
    test_pause();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: entries per source buffer, power of two, minimum 4.
REQ-002 The block SHALL have parameter ROB_BITS, default `ROB_INDEX_BIT: width of all ROB id fields.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk_in  input  1  single clock; all state updates on rising edge
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  pause when low
- clear  input  1  pipeline flush (mispredict)
- alu_ready  input  1  ALU result valid, single-cycle pulse, no backpressure
- alu_rob_id  input  ROB_BITS  ALU result tag
- alu_result  input  32  ALU result value
- lsb_ready  input  1  load/store result valid, single-cycle pulse, no backpressure
- lsb_rob_id  input  ROB_BITS  LSB result tag
- lsb_result  input  32  LSB result value
- alu_stall  output  1  ALU buffer near full; RS SHALL stop issuing
- lsb_stall  output  1  LSB buffer near full
- cdb_req  output  1  broadcast valid, registered
- cdb_rob_id  output  ROB_BITS  broadcast tag, registered
- cdb_val  output  32  broadcast value, registered
- overflow  output  1  sticky error flag, registered

Function
REQ-004 Source 0 = ALU, source 1 = LSB; each source SHALL own a FIFO of FIFO_DEPTH {rob_id, value} entries with read pointer, write pointer and count (0..FIFO_DEPTH).
REQ-005 Per cycle, a source's candidate SHALL be its FIFO head if count > 0, else its current input if ready is high, else none.
REQ-006 Exactly one candidate SHALL be granted per cycle; with one candidate it wins; with two, the source other than last_grant wins.
REQ-007 last_grant SHALL update to the winner on every grant and hold when nothing is granted.
REQ-008 On a grant, cdb_req SHALL be 1 and cdb_rob_id/cdb_val SHALL equal the winner's entry on the cycle after the edge; with no grant cdb_req SHALL be 0 and tag/value hold.
REQ-009 Latency: a result arriving at cycle N with an empty own FIFO and no contention SHALL appear on the CDB in cycle N+1; a buffered result SHALL wait until it heads its FIFO and wins.
REQ-010 An input with ready high SHALL be pushed into its FIFO unless it was the granted candidate directly (bypass); a granted head SHALL be popped in the same cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-011 Per-source order SHALL be preserved: a source's results leave in arrival order.
REQ-012 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 A push when count == FIFO_DEPTH and no pop SHALL drop the input and set overflow to 1; overflow holds until reset.
REQ-014 alu_stall (lsb_stall) SHALL be combinational: 1 when that source's count >= FIFO_DEPTH-2.
REQ-015 When rdy_in is low, all state and outputs SHALL hold and inputs SHALL be ignored.
REQ-016 When clear is high (with rdy_in high), both FIFOs SHALL be emptied, inputs that cycle dropped, cdb_req SHALL be 0 on the next cycle, last_grant and overflow unchanged.
REQ-017 clear SHALL take priority over grant and push in the same cycle; rst_in SHALL take priority over clear and rdy_in.

Reset
REQ-018 On rst_in high at an edge: counts and pointers 0, cdb_req 0, cdb_rob_id 0, cdb_val 0, overflow 0, last_grant = LSB (ALU wins first tie).
REQ-019 Reset asserted mid-operation SHALL discard all buffered results; no broadcast occurs in the cycle following reset.

Verification
REQ-020 Single ALU pulse id 3 val 0x11 at cycle 5 -> cdb_req=1, id 3, val 0x11 in cycle 6 only; cdb_req=0 in cycle 7.
REQ-021 ALU id 1 and LSB id 2 in same cycle after reset -> CDB shows id 1 next cycle, id 2 the cycle after; counts return to 0.
REQ-022 ALU pulses ids 4,5,6,7 on consecutive cycles with LSB pulses ids 8,9,10,11 -> alternating grants, ALU order 4,5,6,7 and LSB order 8..11 preserved, alu_stall asserts at count 2, overflow stays 0.
REQ-023 Five ALU pulses buffered while LSB wins every tie scenario forced with FIFO_DEPTH=4 full and a further push -> overflow=1 and stays 1 until rst_in.
REQ-024 Three entries buffered then clear pulse -> cdb_req=0 next cycle, counts 0, no buffered id ever broadcast.
REQ-025 rdy_in low for 3 cycles with pending entries and input pulses -> outputs frozen, inputs ignored, draining resumes in order when rdy_in returns high.
